ifft256_sched: RTL and testbench

//   Control/address scheduler for the in-place radix-2 memory-based 256-point IFFT engine.

---
 rtl/ifft256_pkg.sv | 27 ++
 rtl/ifft256_sched_delay_line.sv | 29 ++
 rtl/ifft256_sched.sv | 160 ++++++++++++++++
 tb/tb_ifft256_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft256_pkg.sv
// Shared types, sizes and helpers for the 256-point IFFT scheduler.
package ifft256_pkg;

    localparam int N     = 256;
    localparam int LOG2N = 8;
    localparam int NBF   = 128;
    localparam int AW    = 8;
    localparam int TW    = 7;
    localparam int SW    = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        OUT
    } state_e;

    function automatic logic [AW-1:0] bitrev8(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = x[AW-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft256_sched_delay_line.sv
// Reset-clearable shift register used to align write-back with issue.
module ifft_delay_line #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ifft256_sched.sv
// In-place radix-2 256-point IFFT address/control scheduler.
// Define IFFT_SCALE_EN to halve butterfly outputs on every stage.
module ifft256_sched
    import ifft256_pkg::*;
#(
    parameter int LOG2N  = 8,
    parameter int BF_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          ld_we_o,
    output logic [AW-1:0] ld_addr_o,
    output logic          bf_issue_o,
    output logic [AW-1:0] bf_addr_a_o,
    output logic [AW-1:0] bf_addr_b_o,
    output logic [TW-1:0] tw_idx_o,
    output logic          bf_shift_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_a_o,
    output logic [AW-1:0] wb_addr_b_o,
    output logic [SW-1:0] stage_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          out_valid_o,
    output logic          busy_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          out_valid_q;

    logic [AW-1:0] k, span, pos, grp, addr_a, addr_b;
    logic [TW-1:0] tw;
    logic [2*AW:0] wb_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            out_valid_q <= rd_en_o;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = LOAD;
                    cnt_d   = 8'd1;
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(N-1)) state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(NBF-1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                // hold off the next stage until every write-back has landed
                if (cnt_q == 8'(BF_LAT-1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(LOG2N-1)) begin
                        state_d = OUT;
                    end else begin
                        state_d = CALC;
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            OUT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(N-1)) begin
                    state_d = IDLE;
                    stage_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign k      = {1'b0, cnt_q[6:0]};
    assign span   = 8'd1 << stage_q;
    assign pos    = k & (span - 8'd1);
    assign grp    = k >> stage_q;
    assign addr_a = (grp << ({1'b0, stage_q} + 4'd1)) | pos;
    assign addr_b = addr_a + span;
    assign tw     = TW'(pos << (3'd7 - stage_q));

    always_comb begin
        ld_we_o     = 1'b0;
        ld_addr_o   = '0;
        bf_issue_o  = 1'b0;
        bf_addr_a_o = '0;
        bf_addr_b_o = '0;
        tw_idx_o    = '0;
        rd_en_o     = 1'b0;
        rd_addr_o   = '0;
        unique case (state_q)
            IDLE, LOAD: begin
                ld_we_o   = in_valid_i;
                ld_addr_o = bitrev8(cnt_q);
            end
            CALC: begin
                bf_issue_o  = 1'b1;
                bf_addr_a_o = addr_a;
                bf_addr_b_o = addr_b;
                tw_idx_o    = tw;
            end
            OUT: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cnt_q;
            end
            default: ;
        endcase
    end

    ifft_delay_line #(
        .WIDTH(2*AW+1),
        .DEPTH(BF_LAT)
    ) u_wb_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({bf_issue_o, bf_addr_a_o, bf_addr_b_o}),
        .q_o  (wb_bus)
    );

    assign wb_we_o     = wb_bus[2*AW];
    assign wb_addr_a_o = wb_bus[2*AW-1:AW];
    assign wb_addr_b_o = wb_bus[AW-1:0];

`ifdef IFFT_SCALE_EN
    assign bf_shift_o = bf_issue_o;
`else
    assign bf_shift_o = 1'b0;
`endif

    assign stage_o     = stage_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ifft256_sched.sv
// Directed bench for ifft256_sched: vector table plus multi-cycle sequences.
module tb_ifft256_sched;

    localparam int BF_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       ld_we;
    logic [7:0] ld_addr;
    logic       bf_issue;
    logic [7:0] bf_addr_a, bf_addr_b;
    logic [6:0] tw_idx;
    logic       bf_shift;
    logic       wb_we;
    logic [7:0] wb_addr_a, wb_addr_b;
    logic [2:0] stage;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       out_valid;
    logic       busy;

    ifft256_sched #(.LOG2N(8), .BF_LAT(BF_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .ld_we_o    (ld_we),
        .ld_addr_o  (ld_addr),
        .bf_issue_o (bf_issue),
        .bf_addr_a_o(bf_addr_a),
        .bf_addr_b_o(bf_addr_b),
        .tw_idx_o   (tw_idx),
        .bf_shift_o (bf_shift),
        .wb_we_o    (wb_we),
        .wb_addr_a_o(wb_addr_a),
        .wb_addr_b_o(wb_addr_b),
        .stage_o    (stage),
        .rd_en_o    (rd_en),
        .rd_addr_o  (rd_addr),
        .out_valid_o(out_valid),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    wire [64:0] allo = {ld_we, ld_addr, bf_issue, bf_addr_a, bf_addr_b,
                        tw_idx, bf_shift, wb_we, wb_addr_a, wb_addr_b,
                        stage, rd_en, rd_addr, out_valid, busy};

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] brev(input int i);
        logic [7:0] v, r;
        v = 8'(i);
        for (int j = 0; j < 8; j++) r[j] = v[7-j];
        return r;
    endfunction

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] b;
    } wb_t;

    wb_t        wbq[$];
    wb_t        we_e;
    logic [7:0] log_a  [8][128];
    logic [7:0] log_b  [8][128];
    logic [6:0] log_tw [8][128];
    int         kc[8];
    int         ld_cnt = 0;
    int         rd_cnt = 0;
    int         ov_run = 0;
    int         ov_rise[$];
    int         ov_len[$];
    logic       prev_rd = 1'b0;
    logic       prev_ov = 1'b0;
    int         ms, mk;

    initial for (int s = 0; s < 8; s++) kc[s] = 0;

    // mid-cycle monitor: issue/write-back pairing, RAW ordering, read-out
    always @(negedge clk) begin
        if (!rst_n) begin
            wbq.delete();
            prev_rd = 1'b0;
            prev_ov = 1'b0;
            ov_run  = 0;
        end else begin
            if (ld_we) ld_cnt++;
            if (wb_we) begin
                if (wbq.size() == 0) begin
                    chk("wb_spurious", 1, 0);
                end else begin
                    we_e = wbq.pop_front();
                    chk("wb_addr_a", wb_addr_a, we_e.a);
                    chk("wb_addr_b", wb_addr_b, we_e.b);
                    chk("wb_latency", cyc - we_e.c, BF_LAT);
                end
            end else if (wbq.size() != 0 && cyc - wbq[0].c >= BF_LAT) begin
                chk("wb_missing", 0, 1);
                we_e = wbq.pop_front();
            end
            if (bf_issue) begin
                ms = int'(stage);
                mk = kc[ms] % 128;
                if (mk == 0 && ms != 0) chk("raw_pending_wb", wbq.size(), 0);
                log_a[ms][mk]  = bf_addr_a;
                log_b[ms][mk]  = bf_addr_b;
                log_tw[ms][mk] = tw_idx;
                kc[ms]++;
                wbq.push_back('{cyc, bf_addr_a, bf_addr_b});
            end
            if (bf_issue || bf_shift) begin
`ifdef IFFT_SCALE_EN
                chk("bf_shift", bf_shift, bf_issue);
`else
                chk("bf_shift", bf_shift, 0);
`endif
            end
            if (rd_en) begin
                chk("rd_addr", rd_addr, rd_cnt % 256);
                rd_cnt++;
            end
            if (!rd_en && prev_rd) chk("busy_fall", busy, 0);
            if (out_valid && !prev_ov) begin
                ov_rise.push_back(cyc);
                ov_run = 0;
            end
            if (out_valid) ov_run++;
            if (!out_valid && prev_ov) ov_len.push_back(ov_run);
            prev_rd = rd_en;
            prev_ov = out_valid;
        end
    end

    typedef struct {
        int         s;
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
    } bvec_t;

    bvec_t tbl[14];

    task automatic load_frame(input int gap, output int t_last);
        t_last = 0;
        for (int i = 0; i < 256; i++) begin
            if (gap != 0 && i != 0 && i % 10 == 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            #1;
            chk("ld_we", ld_we, 1);
            chk("ld_addr", ld_addr, brev(i));
            t_last = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (!(rd_cnt == target && !rd_en) && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4000) chk("frame_timeout", 1, 0);
    endtask

    task automatic check_frames(input int nfr, input int tl0, input int tl1);
        chk("ld_count", ld_cnt, 256 * nfr);
        chk("rd_count", rd_cnt, 256 * nfr);
        for (int s = 0; s < 8; s++) chk("stage_bf_count", kc[s], 128 * nfr);
        chk("ov_frames", ov_rise.size(), nfr);
        chk("ov_runs", ov_len.size(), nfr);
        if (ov_rise.size() >= 1) chk("latency_f0", ov_rise[0] - tl0, 1050);
        if (ov_rise.size() >= 2) chk("latency_f1", ov_rise[1] - tl1, 1050);
        for (int f = 0; f < ov_len.size(); f++) chk("ov_len", ov_len[f], 256);
    endtask

    int t1, t2, t3, t4, n;

    initial begin
        tbl[0]  = '{0,   0, 8'd0,   8'd1,   7'd0};
        tbl[1]  = '{0,   1, 8'd2,   8'd3,   7'd0};
        tbl[2]  = '{0, 127, 8'd254, 8'd255, 7'd0};
        tbl[3]  = '{1,   0, 8'd0,   8'd2,   7'd0};
        tbl[4]  = '{1,   1, 8'd1,   8'd3,   7'd64};
        tbl[5]  = '{1,   2, 8'd4,   8'd6,   7'd0};
        tbl[6]  = '{3,   5, 8'd5,   8'd13,  7'd80};
        tbl[7]  = '{3,  13, 8'd21,  8'd29,  7'd80};
        tbl[8]  = '{4, 100, 8'd196, 8'd212, 7'd32};
        tbl[9]  = '{6,  70, 8'd134, 8'd198, 7'd12};
        tbl[10] = '{7,   0, 8'd0,   8'd128, 7'd0};
        tbl[11] = '{7,   1, 8'd1,   8'd129, 7'd1};
        tbl[12] = '{7, 127, 8'd127, 8'd255, 7'd127};
        tbl[13] = '{5,  33, 8'd65,  8'd97,  7'd4};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", allo, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outputs", allo, 0);

        // frame 1: back-to-back load, in_valid poked during CALC
        load_frame(0, t1);
        #1;
        chk("first_issue", bf_issue, 1);
        chk("first_addr", {bf_addr_a, bf_addr_b}, 16'h0001);
        chk("first_stage", stage, 0);
        chk("busy_calc", busy, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            #1;
            chk("ld_in_calc", ld_we, 0);
        end
        in_valid = 1'b0;
        wait_done(256);
        chk("busy_after_out", busy, 0);

        // frame 2 starts right after the last read, with input gaps
        load_frame(3, t2);
        wait_done(512);
        repeat (3) @(posedge clk);
        #1;
        check_frames(2, t1, t2);

        for (int v = 0; v < 14; v++) begin
            chk("tbl_addr_a", log_a[tbl[v].s][tbl[v].k], tbl[v].a);
            chk("tbl_addr_b", log_b[tbl[v].s][tbl[v].k], tbl[v].b);
            chk("tbl_tw", log_tw[tbl[v].s][tbl[v].k], tbl[v].tw);
        end
        for (int k = 0; k < 128; k++) begin
            chk("s0_pair", {log_a[0][k], log_b[0][k], log_tw[0][k]},
                {8'(2*k), 8'(2*k+1), 7'd0});
            chk("s7_pair", {log_a[7][k], log_b[7][k], log_tw[7][k]},
                {8'(k), 8'(k+128), 7'(k)});
        end

        // frame 3: reset in stage 4 with write-backs in flight
        load_frame(0, t3);
        n = 0;
        while (!(stage == 3'd4 && bf_issue) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) chk("stage4_timeout", 1, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_wb", wb_we, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", allo, 0);
        ld_cnt = 0;
        rd_cnt = 0;
        for (int s = 0; s < 8; s++) kc[s] = 0;
        ov_rise.delete();
        ov_len.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < BF_LAT + 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_quiet", {wb_we, busy, bf_issue}, 0);
        end

        // frame 4: clean frame after the reset
        load_frame(0, t4);
        wait_done(256);
        repeat (3) @(posedge clk);
        #1;
        check_frames(1, t4, t4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
